// File: rtl/coin_intake_queue.sv
// rtl/coin_intake_queue.sv - debounced coin intake with holding FIFO and reject path
//
// Turns raw per-lane coin sensor levels into clean one-hot, single-cycle coin
// pulses, queueing them while the machine is busy dispensing.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   i_coin_sense   raw per-lane sensor level, high while a coin is in the slot
//   current_state  machine FSM state; pulses are issued only in s0/s1
//   o_input_coin   one-hot, single-cycle accepted coin pulse
//   o_reject_coin  one-hot, single-cycle pulse when a coin is bounced (FIFO full)
//   o_fifo_count   number of queued coins
//   o_busy         any coin pending arbitration or queued
module coin_intake_queue #(
   parameter int kNumCoins = 3,
   parameter int DEPTH     = 4,
   parameter int DEBOUNCE  = 3,
   parameter int GAP       = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [kNumCoins-1:0]         i_coin_sense,
   input  logic [1:0]                   current_state,
   output logic [kNumCoins-1:0]         o_input_coin,
   output logic [kNumCoins-1:0]         o_reject_coin,
   output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
   output logic                         o_busy
);

   localparam int LW = (kNumCoins > 1) ? $clog2(kNumCoins) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;

   typedef enum logic {
      DISARMED = 1'b0,
      ARMED    = 1'b1
   } lane_state_t;

   logic [kNumCoins-1:0] r_sense;
   lane_state_t          r_lane       [kNumCoins];
   lane_state_t          w_lane_nxt   [kNumCoins];
   logic [DW-1:0]        r_db_cnt     [kNumCoins];
   logic [DW-1:0]        w_db_cnt_nxt [kNumCoins];
   logic [kNumCoins-1:0] w_qualify;
   logic [kNumCoins-1:0] r_pending;
   logic [kNumCoins-1:0] w_clear;

   logic [LW-1:0]        r_mem [DEPTH];
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [NW-1:0]        r_count;
   logic [GW-1:0]        r_gap;

   logic                 w_any;
   logic [LW-1:0]        w_sel;
   logic                 w_pop;
   logic                 w_room;
   logic                 w_push;
   logic                 w_reject;

   // Per-lane debounce. Both states count runs of the level they are waiting
   // for (high when ARMED, low when DISARMED); any other sample restarts the run.
   always_comb begin
      w_qualify = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         w_lane_nxt[i]   = r_lane[i];
         w_db_cnt_nxt[i] = r_db_cnt[i];
         if (r_sense[i] == (r_lane[i] == ARMED)) begin
            if (r_db_cnt[i] == DW'(DEBOUNCE - 1)) begin
               w_db_cnt_nxt[i] = '0;
               if (r_lane[i] == ARMED) begin
                  w_qualify[i]  = 1'b1;
                  w_lane_nxt[i] = DISARMED;
               end else begin
                  w_lane_nxt[i] = ARMED;
               end
            end else begin
               w_db_cnt_nxt[i] = r_db_cnt[i] + DW'(1);
            end
         end else begin
            w_db_cnt_nxt[i] = '0;
         end
      end
   end

   // Lowest-index pending lane wins; the scan runs high to low so the last
   // match is the lowest index.
   always_comb begin
      w_any = |r_pending;
      w_sel = '0;
      for (int i = kNumCoins - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_sel = LW'(i);
         end
      end
   end

   assign w_clear  = w_any ? (kNumCoins'(1) << w_sel) : '0;
   assign w_pop    = !reset && (r_count != '0) && (r_gap == '0)
                     && ((current_state == S0) || (current_state == S1));
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_room   = (r_count != NW'(DEPTH)) || w_pop;
   assign w_push   = !reset && w_any && w_room;
   assign w_reject = !reset && w_any && !w_room;

   assign o_input_coin  = w_pop ? (kNumCoins'(1) << r_mem[r_rd_ptr]) : '0;
   assign o_reject_coin = w_reject ? w_clear : '0;
   assign o_fifo_count  = r_count;
   assign o_busy        = (|r_pending) || (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sense   <= '0;
         r_pending <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_gap     <= '0;
         for (int i = 0; i < kNumCoins; i++) begin
            r_lane[i]   <= DISARMED;
            r_db_cnt[i] <= '0;
         end
      end else begin
         r_sense <= i_coin_sense;
         for (int i = 0; i < kNumCoins; i++) begin
            r_lane[i]   <= w_lane_nxt[i];
            r_db_cnt[i] <= w_db_cnt_nxt[i];
         end
         // Serviced lane (pushed or rejected) is cleared; a fresh qualification wins.
         r_pending <= (r_pending & ~w_clear) | w_qualify;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + NW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - NW'(1);
         end
         if (w_pop) begin
            r_gap <= GW'(GAP);
         end else if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
         end
      end
   end

endmodule
